clk_gate_ctrl: RTL

- Low-power clock-gating sequencer that sits directly upstream of the system clock generator.
- Produces the gate_en0 (switch CPU to slow clock) and gate_en1 (stop CPU clock) controls that the clock generator consumes.
- Sequences entry and exit using a CPU low-power request handshake, programmable settle delays and a small APB register file.
- Runs on the free-running pad clock, so it stays alive while the CPU clock is gated.

---
 rtl/clk_gate_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// clk_gate_ctrl : CPU clock-gating sequencer (slow/off entry, timed wake)
// Rev 1.0
// ============================================================================
module clk_gate_ctrl #(
  parameter int ENTER_DLY = 4,
  parameter int WAKE_DLY  = 8,
  parameter int CNT_W     = 4
) (
  input  logic        i_pad_clk,
  input  logic        clkrst_b,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        lp_req,
  input  logic [1:0]  lp_mode,
  input  logic        wake_req,
  output logic        gate_en0,
  output logic        gate_en1,
  output logic        lp_ack,
  output logic        wake_ack
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTER = 3'd1,
    ST_SLOW  = 3'd2,
    ST_OFF   = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ENTER_LOAD = CNT_W'(ENTER_DLY - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_ENTRY  = 2'd2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             off_sel_q, off_sel_d;
  logic             en_q, en_d;
  logic             force_off_q, force_off_d;
  logic [7:0]       entry_cnt_q, entry_cnt_d;
  logic             gate_en0_q, gate_en0_d;
  logic             gate_en1_q, gate_en1_d;
  logic             lp_ack_q, lp_ack_d;
  logic             wake_ack_q, wake_ack_d;

  logic             apb_wr;
  logic             ctrl_wr;
  logic             entry_ok;
  logic [31:0]      rd_data;

  // Only CTRL bits [1:0] and address bits [3:2] carry meaning.
  logic             unused_apb;
  assign unused_apb = ^{pwdata[31:2], paddr[1:0]};

  always_comb begin
    apb_wr      = psel & penable & pwrite;
    ctrl_wr     = apb_wr && (paddr[3:2] == ADDR_CTRL);
    en_d        = en_q;
    force_off_d = force_off_q;
    if (ctrl_wr) begin
      en_d        = pwdata[0];
      force_off_d = pwdata[1];
    end
  end

  // A same-cycle write clearing en vetoes entry; a write setting en does not
  // enable entry until the following cycle.
  assign entry_ok = en_q && !(ctrl_wr && !pwdata[0]) &&
                    lp_req && (lp_mode != 2'b00) && !wake_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_sel_d   = off_sel_q;
    entry_cnt_d = entry_cnt_q;
    wake_ack_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (entry_ok) begin
          state_d   = ST_ENTER;
          cnt_d     = ENTER_LOAD;
          off_sel_d = force_off_q | lp_mode[1];
        end
      end
      ST_ENTER: begin
        if (wake_req || !lp_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d     = off_sel_q ? ST_OFF : ST_SLOW;
          entry_cnt_d = entry_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SLOW, ST_OFF: begin
        if (wake_req || !lp_req || !en_q) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          wake_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Decoded from next state so the gate controls flip with the state flop.
    gate_en0_d = (state_d == ST_SLOW);
    gate_en1_d = (state_d == ST_OFF);
    lp_ack_d   = (state_d == ST_SLOW) || (state_d == ST_OFF);
  end

  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_sel_q   <= 1'b0;
      en_q        <= 1'b0;
      force_off_q <= 1'b0;
      entry_cnt_q <= 8'h00;
      gate_en0_q  <= 1'b0;
      gate_en1_q  <= 1'b0;
      lp_ack_q    <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_sel_q   <= off_sel_d;
      en_q        <= en_d;
      force_off_q <= force_off_d;
      entry_cnt_q <= entry_cnt_d;
      gate_en0_q  <= gate_en0_d;
      gate_en1_q  <= gate_en1_d;
      lp_ack_q    <= lp_ack_d;
      wake_ack_q  <= wake_ack_d;
    end
  end

  always_comb begin
    rd_data = 32'h0000_0000;
    if (psel) begin
      case (paddr[3:2])
        ADDR_CTRL:   rd_data = {30'b0, force_off_q, en_q};
        ADDR_STATUS: rd_data = {21'b0, gate_en1_q, gate_en0_q, lp_ack_q, 5'b0, state_q};
        ADDR_ENTRY:  rd_data = {24'b0, entry_cnt_q};
        default:     rd_data = 32'h0000_0000;
      endcase
    end
  end

  assign prdata   = rd_data;
  assign gate_en0 = gate_en0_q;
  assign gate_en1 = gate_en1_q;
  assign lp_ack   = lp_ack_q;
  assign wake_ack = wake_ack_q;

endmodule
`default_nettype wire
